// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps one imem request in flight,
// and hands instructions to decode through a valid/stall port backed by a one-entry skid.
`timescale 1ns/1ps
module fetch_ctrl #(
  parameter int unsigned            PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_target,
  input  logic                stall,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  output logic [PC_WIDTH-1:0] pc,
  output logic                instr_valid,
  output logic [31:0]         instr,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic [PC_WIDTH-1:0] PC_Plus
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_FLUSH, S_HOLD} state_t;

  state_t              state, state_n;
  logic [PC_WIDTH-1:0] pc_n, instr_pc_n, skid_pc, skid_pc_n, target;
  logic                instr_valid_n, skid_valid, skid_valid_n, out_free;
  logic [31:0]         instr_n, skid_data, skid_data_n;

  assign target    = redirect_target & ~PC_WIDTH'(3);
  assign out_free  = !instr_valid || !stall;
  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;
  assign PC_Plus   = instr_pc + PC_WIDTH'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      skid_pc     <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr_valid <= instr_valid_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      skid_valid  <= skid_valid_n;
      skid_data   <= skid_data_n;
      skid_pc     <= skid_pc_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    instr_valid_n = instr_valid;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    skid_valid_n  = skid_valid;
    skid_data_n   = skid_data;
    skid_pc_n     = skid_pc;

    if (instr_valid && !stall)
      instr_valid_n = 1'b0;

    case (state)
      S_IDLE: begin
        state_n = S_REQ;
        if (redirect) pc_n = target;
      end
      S_REQ: begin
        if (redirect) begin
          pc_n    = target;
          state_n = imem_gnt ? S_FLUSH : S_REQ;
        end else if (imem_gnt) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_n    = target;
          state_n = imem_rvalid ? S_REQ : S_FLUSH;
        end else if (imem_rvalid) begin
          pc_n = pc + PC_WIDTH'(4);
          if (out_free) begin
            instr_valid_n = 1'b1;
            instr_n       = imem_rdata;
            instr_pc_n    = pc;
            state_n       = S_REQ;
          end else begin
            skid_valid_n = 1'b1;
            skid_data_n  = imem_rdata;
            skid_pc_n    = pc;
            state_n      = S_HOLD;
          end
        end
      end
      S_FLUSH: begin
        if (redirect)    pc_n    = target;
        if (imem_rvalid) state_n = S_REQ;
      end
      S_HOLD: begin
        if (redirect) begin
          pc_n    = target;
          state_n = S_REQ;
        end else if (!stall) begin
          instr_valid_n = 1'b1;
          instr_n       = skid_data;
          instr_pc_n    = skid_pc;
          skid_valid_n  = 1'b0;
          state_n       = S_REQ;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Output and skid hold instructions younger than the redirecting one; kill them last so this wins.
    if (redirect) begin
      instr_valid_n = 1'b0;
      skid_valid_n  = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: grant addresses and delivered instructions are
// checked by a scoreboard monitor; a second instance starts at the top of memory.
`timescale 1ns/1ps
module tb_fetch_ctrl;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, redirect, stall, imem_gnt, imem_rvalid;
  logic [31:0] redirect_target, imem_rdata;
  logic        imem_req, instr_valid, w_imem_req, w_instr_valid;
  logic [31:0] imem_addr, pc, instr, instr_pc, PC_Plus;
  logic [31:0] w_imem_addr, w_pc, w_instr, w_instr_pc, w_PC_Plus;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  exp_t        mon_e;
  logic [31:0] mon_a;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.PC_WIDTH(32), .RESET_PC(32'h0000_0100)) u_dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_target(redirect_target),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc(pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .PC_Plus(PC_Plus)
  );

  fetch_ctrl #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_target(redirect_target),
    .stall(stall), .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pc(w_pc),
    .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc), .PC_Plus(w_PC_Plus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: grants and consumed instructions are matched against queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req && imem_gnt) begin
        if (addr_q.size() == 0) begin
          chk("unexpected_grant", imem_addr, 32'hDEAD_DEAD);
        end else begin
          mon_a = addr_q.pop_front();
          chk("imem_addr", imem_addr, mon_a);
        end
      end
      if (instr_valid && !stall && !redirect) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_instr", instr_pc, 32'hDEAD_DEAD);
        end else begin
          mon_e = exp_q.pop_front();
          chk("instr", instr, mon_e.data);
          chk("instr_pc", instr_pc, mon_e.pc);
          chk("PC_Plus", PC_Plus, mon_e.pc + 32'd4);
        end
      end
    end
  end

  task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                      input logic rdr, input logic [31:0] tg, input logic st);
    imem_gnt        = g;
    imem_rvalid     = rv;
    imem_rdata      = rd;
    redirect        = rdr;
    redirect_target = tg;
    stall           = st;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic push_addr(input logic [31:0] a);
    addr_q.push_back(a);
  endtask

  task automatic push_instr(input logic [31:0] d, input logic [31:0] p);
    exp_t e;
    e.data = d;
    e.pc   = p;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    idle();
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h100);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_PC_Plus", PC_Plus, 32'd4);
    rst = 1'b0;
  endtask

  task automatic drained(input string name);
    chk({name, "_addr_left"}, addr_q.size(), 32'd0);
    chk({name, "_instr_left"}, exp_q.size(), 32'd0);
    addr_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_target = '0; stall = 1'b0;

    // Startup / streaming, plus wrap instance
    do_reset();
    idle();                                                   // IDLE
    chk("wrap_addr0", w_imem_addr, 32'hFFFF_FFFC);
    chk("wrap_req0", {31'b0, w_imem_req}, 32'd1);
    push_addr(32'h100);          step(1, 0, 0, 0, 0, 0);      // REQ
    push_instr(32'hA000_0001, 32'h100); step(0, 1, 32'hA000_0001, 0, 0, 0);
    chk("wrap_valid", {31'b0, w_instr_valid}, 32'd1);
    chk("wrap_instr_pc", w_instr_pc, 32'hFFFF_FFFC);
    chk("wrap_PC_Plus", w_PC_Plus, 32'h0);
    chk("wrap_addr1", w_imem_addr, 32'h0);
    push_addr(32'h104);          step(1, 0, 0, 0, 0, 0);
    push_instr(32'hB000_0002, 32'h104); step(0, 1, 32'hB000_0002, 0, 0, 0);
    push_addr(32'h108);          step(1, 0, 0, 0, 0, 0);
    push_instr(32'hC000_0003, 32'h108); step(0, 1, 32'hC000_0003, 0, 0, 0);
    idle();
    drained("startup");

    // Wait states: grant after 3 REQ cycles, response after 2 WAIT cycles
    do_reset();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("ws_req", {31'b0, imem_req}, 32'd1);
      chk("ws_addr_hold", imem_addr, 32'h100);
      idle();
    end
    push_addr(32'h100);          step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      chk("ws_wait_noreq", {31'b0, imem_req}, 32'd0);
      idle();
    end
    push_instr(32'hD000_0004, 32'h100); step(0, 1, 32'hD000_0004, 0, 0, 0);
    idle();
    idle();
    chk("ws_next_addr", imem_addr, 32'h104);
    drained("waitstates");

    // Redirect in WAIT: flush drops the stale response
    do_reset();
    idle();
    push_addr(32'h100);          step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h2003, 0);                            // WAIT + redirect
    chk("rw_flush_noreq", {31'b0, imem_req}, 32'd0);
    chk("rw_pc", pc, 32'h2000);
    step(0, 1, 32'hBAD0_0000, 0, 0, 0);                       // FLUSH drops
    chk("rw_dropped", {31'b0, instr_valid}, 32'd0);
    chk("rw_addr", imem_addr, 32'h2000);
    push_addr(32'h2000);         step(1, 0, 0, 0, 0, 0);
    push_instr(32'hE000_0005, 32'h2000); step(0, 1, 32'hE000_0005, 0, 0, 0);
    idle();
    drained("redir_wait");

    // Redirect together with rvalid in WAIT
    do_reset();
    idle();
    push_addr(32'h100);          step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'hBAD0_0001, 1, 32'h3000, 0);
    chk("rr_dropped", {31'b0, instr_valid}, 32'd0);
    chk("rr_req", {31'b0, imem_req}, 32'd1);
    push_addr(32'h3000);         step(1, 0, 0, 0, 0, 0);
    push_instr(32'hF000_0006, 32'h3000); step(0, 1, 32'hF000_0006, 0, 0, 0);
    idle();
    drained("redir_rvalid");

    // Redirect in REQ: ungranted moves address, granted goes through FLUSH
    do_reset();
    idle();
    step(0, 0, 0, 1, 32'h5006, 0);
    chk("rg_req", {31'b0, imem_req}, 32'd1);
    chk("rg_addr_moved", imem_addr, 32'h5004);
    push_addr(32'h5004);         step(1, 0, 0, 1, 32'h4000, 0);
    chk("rg_flush_noreq", {31'b0, imem_req}, 32'd0);
    chk("rg_pc", imem_addr, 32'h4000);
    step(0, 1, 32'hBAD0_0002, 0, 0, 0);
    chk("rg_dropped", {31'b0, instr_valid}, 32'd0);
    push_addr(32'h4000);         step(1, 0, 0, 0, 0, 0);
    push_instr(32'h1111_0007, 32'h4000); step(0, 1, 32'h1111_0007, 0, 0, 0);
    idle();
    drained("redir_gnt");

    // Stall with response in flight: skid then release
    do_reset();
    idle();
    push_addr(32'h100);          step(1, 0, 0, 0, 0, 0);
    push_instr(32'h2222_0008, 32'h100); step(0, 1, 32'h2222_0008, 0, 0, 1);
    push_addr(32'h104);          step(1, 0, 0, 0, 0, 1);
    push_instr(32'h3333_0009, 32'h104); step(0, 1, 32'h3333_0009, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      chk("hold_noreq", {31'b0, imem_req}, 32'd0);
      chk("hold_valid", {31'b0, instr_valid}, 32'd1);
      chk("hold_instr", instr, 32'h2222_0008);
      chk("hold_instr_pc", instr_pc, 32'h100);
      step(0, 0, 0, 0, 0, 1);
    end
    idle();                                                   // release
    chk("skid_valid", {31'b0, instr_valid}, 32'd1);
    chk("skid_resume_addr", imem_addr, 32'h108);
    push_addr(32'h108);          step(1, 0, 0, 0, 0, 0);
    push_instr(32'h4444_000A, 32'h108); step(0, 1, 32'h4444_000A, 0, 0, 0);
    idle();
    drained("skid");

    // Redirect while in HOLD discards output and skid
    do_reset();
    idle();
    push_addr(32'h100);          step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h5555_000B, 0, 0, 1);
    push_addr(32'h104);          step(1, 0, 0, 0, 0, 1);
    step(0, 1, 32'h6666_000C, 0, 0, 1);
    chk("hr_in_hold", {31'b0, imem_req}, 32'd0);
    step(0, 0, 0, 1, 32'h6000, 1);
    chk("hr_cleared", {31'b0, instr_valid}, 32'd0);
    chk("hr_addr", imem_addr, 32'h6000);
    push_addr(32'h6000);         step(1, 0, 0, 0, 0, 0);
    push_instr(32'h7777_000D, 32'h6000); step(0, 1, 32'h7777_000D, 0, 0, 0);
    chk("hr_no_skid_leak", instr, 32'h7777_000D);
    idle();
    drained("redir_hold");

    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
